// File: rtl/cordic_to_float_pair.sv
// Converts two signed Q2.20 CORDIC results into IEEE-754 single-precision floats.
// Both lanes are normalised in parallel, one left shift per enabled cycle.
module cordic_to_float_pair #(
  parameter int FLT_DATA_WIDTH    = 32,
  parameter int CORDIC_DATA_WIDTH = 22
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clk_en,
  input  logic                         start,
  input  logic [CORDIC_DATA_WIDTH-1:0] in_one,
  input  logic [CORDIC_DATA_WIDTH-1:0] in_two,
  output logic [FLT_DATA_WIDTH-1:0]    out_one,
  output logic [FLT_DATA_WIDTH-1:0]    out_two,
  output logic                         working,
  output logic                         done
);

  localparam int MW      = CORDIC_DATA_WIDTH;
  localparam int EW      = 8;
  localparam int PAD_W   = FLT_DATA_WIDTH - 1 - EW - (MW - 1);
  // The top magnitude bit carries weight 2^1, i.e. biased exponent 127 + 1.
  localparam logic [EW-1:0] EXP_TOP = 8'd128;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    DONE
  } state_t;

  state_t state, state_next;

  logic          sign_one, sign_two;
  logic [MW-1:0] mag_one, mag_two;
  logic [EW-1:0] exp_one, exp_two;

  logic capture, shift_step, pack;
  logic working_next, done_next;
  logic settled_one, settled_two;

  function automatic logic [MW-1:0] magnitude(input logic [MW-1:0] v);
    // The most negative input maps to 2^21, which still fits unsigned.
    return v[MW-1] ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [FLT_DATA_WIDTH-1:0] pack_float(
    input logic          sign,
    input logic [EW-1:0] exp,
    input logic [MW-1:0] mag
  );
    // A zero magnitude always packs as +0.0, regardless of sign.
    if (mag == '0) return '0;
    return {sign, exp, mag[MW-2:0], {PAD_W{1'b0}}};
  endfunction

  assign settled_one = mag_one[MW-1] || (mag_one == '0);
  assign settled_two = mag_two[MW-1] || (mag_two == '0);

  // NOTE: assign every always_comb output a default up front so no path leaves a signal unassigned and infers a latch.
  always_comb begin
    state_next   = state;
    capture      = 1'b0;
    shift_step   = 1'b0;
    pack         = 1'b0;
    working_next = working;
    done_next    = 1'b0;
    case (state)
      IDLE: begin
        working_next = start;
        if (start) begin
          capture    = 1'b1;
          state_next = NORM;
        end
      end
      NORM: begin
        if (settled_one && settled_two) begin
          pack       = 1'b1;
          state_next = DONE;
        end else begin
          shift_step = 1'b1;
        end
      end
      DONE: begin
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else if (clk_en) begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sign_one <= 1'b0;
      sign_two <= 1'b0;
      mag_one  <= '0;
      mag_two  <= '0;
      exp_one  <= '0;
      exp_two  <= '0;
      out_one  <= '0;
      out_two  <= '0;
      working  <= 1'b0;
      done     <= 1'b0;
    end else if (clk_en) begin
      working <= working_next;
      done    <= done_next;
      if (capture) begin
        sign_one <= in_one[MW-1];
        sign_two <= in_two[MW-1];
        mag_one  <= magnitude(in_one);
        mag_two  <= magnitude(in_two);
        exp_one  <= EXP_TOP;
        exp_two  <= EXP_TOP;
      end
      if (shift_step) begin
        // Settled lanes hold while the other lane catches up.
        if (!settled_one) begin
          mag_one <= mag_one << 1;
          exp_one <= exp_one - 1'b1;
        end
        if (!settled_two) begin
          mag_two <= mag_two << 1;
          exp_two <= exp_two - 1'b1;
        end
      end
      if (pack) begin
        out_one <= pack_float(sign_one, exp_one, mag_one);
        out_two <= pack_float(sign_two, exp_two, mag_two);
      end
    end
  end

endmodule

// File: tb/tb_cordic_to_float_pair.sv
// Self-checking bench for cordic_to_float_pair: directed cases plus randomized
// conversions checked against a real-arithmetic reference model.
module tb_cordic_to_float_pair;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        start;
  logic [21:0] in_one, in_two;
  logic [31:0] out_one, out_two;
  logic        working, done;

  int checks = 0;
  int fails  = 0;

  cordic_to_float_pair #(
    .FLT_DATA_WIDTH   (32),
    .CORDIC_DATA_WIDTH(22)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .start  (start),
    .in_one (in_one),
    .in_two (in_two),
    .out_one(out_one),
    .out_two(out_two),
    .working(working),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: the fixed-point value as a real, re-encoded as a single from its double fields.
  function automatic logic [31:0] ref_float(input logic [21:0] v);
    int          iv;
    real         r;
    logic [63:0] bits;
    logic [10:0] e;
    iv = int'($signed(v));
    r  = real'(iv) / 1048576.0;
    if (iv == 0) return 32'h0;
    bits = $realtobits(r);
    e    = bits[62:52] - 11'd896;
    return {bits[63], e[7:0], bits[51:29]};
  endfunction

  // Left shifts needed to bring the magnitude's leading one up to bit 21.
  function automatic int ref_shifts(input logic [21:0] v);
    int m, s;
    m = int'($signed(v));
    if (m < 0) m = -m;
    if (m == 0) return 0;
    s = 0;
    while (m < (1 << 21)) begin
      m = m * 2;
      s++;
    end
    return s;
  endfunction

  task automatic run_conv(input logic [21:0] a, input logic [21:0] b,
                          input bit toggle_en, input bit poke_start);
    int          n, k, cycles;
    logic [31:0] e1, e2;
    bit          en;
    n  = (ref_shifts(a) > ref_shifts(b)) ? ref_shifts(a) : ref_shifts(b);
    e1 = ref_float(a);
    e2 = ref_float(b);
    @(negedge clk);
    in_one = a;
    in_two = b;
    start  = 1'b1;
    clk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("working_after_capture", 32'(working), 32'd1);
    k      = 0;
    cycles = 0;
    while (k < n + 3 && cycles < 400) begin
      en     = toggle_en ? bit'($urandom_range(0, 1)) : 1'b1;
      clk_en = en;
      in_one = 22'($urandom);
      in_two = 22'($urandom);
      start  = poke_start && (k == 0);
      @(posedge clk);
      if (en) k++;
      cycles++;
      @(negedge clk);
      start = 1'b0;
      check("done", 32'(done), 32'(k == n + 2));
      check("working", 32'(working), 32'(k <= n + 2));
      if (k == n + 2 && en) begin
        check("out_one", out_one, e1);
        check("out_two", out_two, e2);
      end
    end
    check("conversion_completed_in_budget", 32'(k), 32'(n + 3));
    check("out_one_held", out_one, e1);
    check("out_two_held", out_two, e2);
    clk_en = 1'b1;
  endtask

  initial begin
    logic [21:0] a, b;
    rst    = 1'b0;
    clk_en = 1'b0;
    start  = 1'b0;
    in_one = '0;
    in_two = '0;
    #12;
    check("reset_out_one", out_one, 32'h0);
    check("reset_out_two", out_two, 32'h0);
    check("reset_working", 32'(working), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    @(negedge clk);
    rst    = 1'b1;
    clk_en = 1'b1;

    // Directed cases.
    run_conv(22'h100000, 22'h080000, 1'b0, 1'b0);
    run_conv(22'h200000, 22'h1FFFFF, 1'b0, 1'b0);
    run_conv(22'h000001, 22'h3FFFFF, 1'b0, 1'b0);
    run_conv(22'h000000, 22'h300000, 1'b0, 1'b0);
    run_conv(22'h100000, 22'h100000, 1'b1, 1'b0);
    run_conv(22'h000003, 22'h3C0000, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a long normalisation.
    @(negedge clk);
    in_one = 22'h000001;
    in_two = 22'h000002;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midnorm_reset_out_one", out_one, 32'h0);
    check("midnorm_reset_out_two", out_two, 32'h0);
    check("midnorm_reset_working", 32'(working), 32'd0);
    check("midnorm_reset_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("idle_done", 32'(done), 32'd0);
      check("idle_working", 32'(working), 32'd0);
    end
    check("idle_out_one", out_one, 32'h0);

    // Randomized conversions with varied magnitudes, signs and enable patterns.
    for (int i = 0; i < 40; i++) begin
      a = 22'($urandom);
      b = 22'($urandom);
      a = 22'($signed(a) >>> $urandom_range(0, 21));
      b = 22'($signed(b) >>> $urandom_range(0, 21));
      run_conv(a, b, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
